serial_monitor: RTL and testbench

Byte-stream debug monitor that sits between the UART receiver/transmitter pair and the cpu's memory port and control pins.

- While the cpu is held in reset, it owns the memory port and can load memory from host bytes, dump memory back to the host, set the start address and release the cpu.
- While the cpu runs, it can halt it; after the halt it can read the register dump the cpu leaves at memory addresses 2..65.

---
 rtl/serial_monitor.sv | 222 ++++++++++++++++++++++
 tb/tb_serial_monitor.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_monitor.sv
// serial_monitor: UART byte-command debug monitor that owns the RAM port and the cpu reset/halt pins.
// Latency: an L write lands one edge after its rx data byte; each dump byte reaches tx 3 cycles after its read starts.
// Backpressure: tx_data/tx_valid are held until tx_ready; rx has none, so bytes arriving in busy states are dropped.
// Ports: clk, reset (synchronous, active-high)
//   rx_data/rx_valid          byte stream from the UART receiver
//   tx_data/tx_valid/tx_ready byte stream to the UART transmitter
//   mem_*                     RAM port; mem_own=1 muxes the RAM to this block, 0 to the cpu
//   cpu_reset/cpu_halt/cpu_halted/start_address  cpu control pins
module serial_monitor #(
  parameter int addr_width = 9  // must be <= 16: the addr/count registers are 16 bits
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            mem_data_out,
  output logic [7:0]            mem_data_in,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic                  mem_write,
  output logic                  mem_own,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  input  logic                  cpu_halted,
  output logic [addr_width-1:0] start_address
);

  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_Q = 8'h3F;

  typedef enum logic [3:0] {
    S_IDLE, S_ARG, S_LDATA, S_DREAD, S_DWAIT, S_DLATCH, S_DSEND, S_RREL, S_HWAIT, S_ACK
  } state_t;

  state_t state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [1:0]            arg_left_q, arg_left_d;  // argument bytes still expected, minus one
  logic [15:0]           addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            mem_data_in_q, mem_data_in_d;
  logic [addr_width-1:0] mem_raddr_q, mem_raddr_d;
  logic [addr_width-1:0] mem_waddr_q, mem_waddr_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_own_q, mem_own_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  cpu_halt_q, cpu_halt_d;
  logic [addr_width-1:0] start_address_q, start_address_d;
  logic [7:0]            ack_byte;

  logic        tx_fire;
  logic        arg_done;
  logic [15:0] arg_last;  // final 16-bit argument, including the byte arriving now

  assign tx_fire  = tx_valid_q & tx_ready;
  assign arg_done = (state_q == S_ARG) && rx_valid && (arg_left_q == 2'd0);
  assign arg_last = {cnt_q[7:0], rx_data};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ack_byte is the reply loaded whenever ACK is entered
  always_comb begin
    state_d  = state_q;
    ack_byte = CH_K;
    case (state_q)
      S_IDLE: if (rx_valid) begin
        case (rx_data)
          CH_L, CH_D: begin
            if (mem_own_q) state_d = S_ARG;
            else begin state_d = S_ACK; ack_byte = CH_E; end
          end
          CH_R:    state_d = S_ARG;
          CH_H:    state_d = cpu_reset_q ? S_ACK : S_HWAIT;
          default: begin state_d = S_ACK; ack_byte = CH_Q; end
        endcase
      end
      S_ARG: if (arg_done) begin
        if (cmd_q == CH_R)          state_d = S_RREL;
        else if (arg_last == 16'd0) state_d = S_ACK;
        else if (cmd_q == CH_L)     state_d = S_LDATA;
        else                        state_d = S_DREAD;
      end
      S_LDATA:  if (rx_valid && cnt_q == 16'd1) state_d = S_ACK;
      S_DREAD:  state_d = S_DWAIT;
      S_DWAIT:  state_d = S_DLATCH;
      S_DLATCH: state_d = S_DSEND;
      S_DSEND:  if (tx_fire) state_d = (cnt_q == 16'd1) ? S_ACK : S_DREAD;
      S_RREL:   state_d = S_ACK;
      S_HWAIT:  if (cpu_halted) state_d = S_ACK;
      S_ACK:    if (tx_fire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    cmd_d           = cmd_q;
    arg_left_d      = arg_left_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    tx_data_d       = tx_data_q;
    tx_valid_d      = tx_valid_q;
    mem_data_in_d   = mem_data_in_q;
    mem_raddr_d     = mem_raddr_q;
    mem_waddr_d     = mem_waddr_q;
    mem_write_d     = 1'b0;
    mem_own_d       = mem_own_q;
    cpu_reset_d     = cpu_reset_q;
    cpu_halt_d      = cpu_halt_q;
    start_address_d = start_address_q;
    case (state_q)
      S_IDLE: if (rx_valid) begin
        cmd_d      = rx_data;
        arg_left_d = (rx_data == CH_R) ? 2'd1 : 2'd3;
        if (rx_data == CH_H && !cpu_reset_q) cpu_halt_d = 1'b1;
      end
      S_ARG: if (rx_valid) begin
        // Big-endian shift: after four bytes addr holds the first pair, cnt the second
        {addr_d, cnt_d} = {addr_q[7:0], cnt_q, rx_data};
        arg_left_d      = arg_left_q - 2'd1;
        if (arg_done && cmd_q == CH_R) begin
          start_address_d = arg_last[addr_width-1:0];
          // mem_own rises with cpu_reset so the pair always moves together, even on a restart
          cpu_reset_d     = 1'b1;
          mem_own_d       = 1'b1;
        end
      end
      S_LDATA: if (rx_valid) begin
        mem_write_d   = 1'b1;
        mem_waddr_d   = addr_q[addr_width-1:0];
        mem_data_in_d = rx_data;
        addr_d        = addr_q + 16'd1;
        cnt_d         = cnt_q - 16'd1;
      end
      S_DREAD:  mem_raddr_d = addr_q[addr_width-1:0];
      S_DLATCH: begin
        tx_data_d  = mem_data_out;
        tx_valid_d = 1'b1;
      end
      S_DSEND: if (tx_fire) begin
        tx_valid_d = 1'b0;
        addr_d     = addr_q + 16'd1;
        cnt_d      = cnt_q - 16'd1;
      end
      S_RREL: begin
        cpu_reset_d = 1'b0;
        mem_own_d   = 1'b0;
      end
      S_HWAIT: if (cpu_halted) begin
        cpu_halt_d  = 1'b0;
        cpu_reset_d = 1'b1;
        mem_own_d   = 1'b1;
      end
      S_ACK:   if (tx_fire) tx_valid_d = 1'b0;
      default: ;
    endcase
    // Every path into ACK loads the reply; this also covers DSEND's last transfer
    if (state_d == S_ACK && state_q != S_ACK) begin
      tx_valid_d = 1'b1;
      tx_data_d  = ack_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q           <= 8'h00;
      arg_left_q      <= 2'd0;
      addr_q          <= 16'h0000;
      cnt_q           <= 16'h0000;
      tx_data_q       <= 8'h00;
      tx_valid_q      <= 1'b0;
      mem_data_in_q   <= 8'h00;
      mem_raddr_q     <= '0;
      mem_waddr_q     <= '0;
      mem_write_q     <= 1'b0;
      mem_own_q       <= 1'b1;
      cpu_reset_q     <= 1'b1;
      cpu_halt_q      <= 1'b0;
      start_address_q <= '0;
    end else begin
      cmd_q           <= cmd_d;
      arg_left_q      <= arg_left_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      mem_data_in_q   <= mem_data_in_d;
      mem_raddr_q     <= mem_raddr_d;
      mem_waddr_q     <= mem_waddr_d;
      mem_write_q     <= mem_write_d;
      mem_own_q       <= mem_own_d;
      cpu_reset_q     <= cpu_reset_d;
      cpu_halt_q      <= cpu_halt_d;
      start_address_q <= start_address_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign mem_data_in   = mem_data_in_q;
  assign mem_raddr     = mem_raddr_q;
  assign mem_waddr     = mem_waddr_q;
  assign mem_write     = mem_write_q;
  assign mem_own       = mem_own_q;
  assign cpu_reset     = cpu_reset_q;
  assign cpu_halt      = cpu_halt_q;
  assign start_address = start_address_q;

endmodule

// File: tb/tb_serial_monitor.sv
// tb_serial_monitor: directed and randomized command sequences for serial_monitor against a byte-level model.
// Latency: replies and memory writes are collected by monitors and compared after each command.
// Backpressure: tx_ready is driven fixed or random; held tx bytes are checked for stability.
module tb_serial_monitor;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    mem_data_out;
  logic [7:0]    mem_data_in;
  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] mem_waddr;
  logic          mem_write;
  logic          mem_own;
  logic          cpu_reset;
  logic          cpu_halt;
  logic          cpu_halted;
  logic [AW-1:0] start_address;

  serial_monitor #(.addr_width(AW)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_write(mem_write),
    .mem_own(mem_own), .cpu_reset(cpu_reset), .cpu_halt(cpu_halt),
    .cpu_halted(cpu_halted), .start_address(start_address)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: registered read address, one-cycle read latency
  logic [7:0] ram [0:511];
  always @(posedge clk) begin
    if (mem_write) ram[mem_waddr] <= mem_data_in;
    mem_data_out <= ram[mem_raddr];
  end

  int          total = 0;
  int          bad = 0;
  logic [7:0]  tx_q[$];
  logic [16:0] wr_q[$];
  logic [7:0]  exp_tx[$];
  logic [16:0] exp_wr[$];
  logic [7:0]  ld_dat[$];
  logic [7:0]  ref_mem [0:511];
  bit          ready_rand = 1'b0;
  logic        ready_fix = 1'b1;
  logic        pend = 1'b0;
  logic [7:0]  pend_dat = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitors sample on the falling edge; inputs change just after the rising edge
  always @(negedge clk) begin
    if (mem_write) wr_q.push_back({mem_waddr, mem_data_in});
    if (reset) pend <= 1'b0;
    else begin
      if (pend) begin
        chk("tx_hold_vld", tx_valid, 1);
        chk("tx_hold_dat", tx_data, pend_dat);
      end
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      pend     <= tx_valid && !tx_ready;
      pend_dat <= tx_data;
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    step(gap);
  endtask

  task automatic send16(input logic [15:0] v, input int gap);
    send(v[15:8], gap);
    send(v[7:0], gap);
  endtask

  task automatic fill_rand(input int n);
    ld_dat.delete();
    for (int i = 0; i < n; i++) ld_dat.push_back(8'($urandom));
  endtask

  // Wait for the expected replies (bounded), then compare replies and RAM writes
  task automatic check_out(input string tag);
    int n;
    n = exp_tx.size();
    for (int c = 0; c < 4000 && tx_q.size() < n; c++) step(1);
    step(3);
    chk({tag, "_ntx"}, tx_q.size(), n);
    for (int i = 0; i < n && tx_q.size() > 0; i++) chk({tag, "_tx"}, tx_q.pop_front(), exp_tx[i]);
    chk({tag, "_nwr"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && wr_q.size() > 0; i++) chk({tag, "_wr"}, wr_q.pop_front(), exp_wr[i]);
    tx_q.delete();
    wr_q.delete();
    exp_tx.delete();
    exp_wr.delete();
  endtask

  task automatic do_load(input logic [15:0] a, input int c, input int gap, input string tag);
    int wa;
    send(8'h4C, gap);
    send16(a, gap);
    send16(16'(c), gap);
    for (int i = 0; i < c; i++) begin
      wa = (int'(a) + i) % 512;
      ref_mem[wa] = ld_dat[i];
      exp_wr.push_back({9'(wa), ld_dat[i]});
      send(ld_dat[i], gap);
    end
    exp_tx.push_back(8'h4B);
    check_out(tag);
  endtask

  task automatic do_dump(input logic [15:0] a, input int c, input int gap, input string tag);
    send(8'h44, gap);
    send16(a, gap);
    send16(16'(c), gap);
    for (int i = 0; i < c; i++) exp_tx.push_back(ref_mem[(int'(a) + i) % 512]);
    exp_tx.push_back(8'h4B);
    check_out(tag);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_tx"}, {tx_valid, tx_data}, 0);
    chk({tag, "_mem"}, {mem_write, mem_data_in, mem_raddr, mem_waddr}, 0);
    chk({tag, "_ctl"}, {mem_own, cpu_reset, cpu_halt}, 3'b110);
    chk({tag, "_start"}, start_address, 0);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    int          c;
    int          gap;
    reset      = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    cpu_halted = 1'b0;
    step(3);
    chk_rst("reset");
    reset = 1'b0;
    step(2);

    // Fill all of memory, starting high so the address wraps
    fill_rand(512);
    do_load(16'h0155, 512, 0, "fill");

    // Load test-plan bytes, back-to-back
    ld_dat = {8'hAA, 8'hBB, 8'hCC};
    do_load(16'h0010, 3, 0, "load");

    // Dump across the wrap with backpressure on the first byte
    ld_dat = {8'h11, 8'h22};
    do_load(16'h01FF, 2, 0, "pre");
    ready_fix = 1'b0;
    send(8'h44, 0);
    send16(16'h01FF, 0);
    send16(16'h0002, 0);
    step(1);
    chk("d_raddr", mem_raddr, 9'h1FF);
    step(1);
    chk("d_lat_lo", tx_valid, 0);
    step(1);
    chk("d_lat_hi", tx_valid, 1);
    chk("d_first", tx_data, 8'h11);
    send(8'h5A, 0);  // arrives while dumping: must be dropped
    step(4);
    chk("d_held", {tx_valid, tx_data}, {1'b1, 8'h11});
    exp_tx = {8'h11, 8'h22, 8'h4B};
    ready_fix = 1'b1;
    check_out("dwrap");

    // Register-dump area the cpu would leave behind
    fill_rand(64);
    do_load(16'h0002, 64, 1, "regs");

    // Release the cpu
    send(8'h52, 0);
    send(8'h00, 0);
    send(8'h20, 0);
    chk("run_arm", {cpu_reset, mem_own, start_address}, {1'b1, 1'b1, 9'h020});
    step(1);
    chk("run_go", {cpu_reset, mem_own, start_address}, {1'b0, 1'b0, 9'h020});
    exp_tx = {8'h4B};
    check_out("run");

    // Rejects while running
    send(8'h4C, 0);
    exp_tx = {8'h45};
    check_out("rej_l");
    send(8'h44, 0);
    exp_tx = {8'h45};
    check_out("rej_d");
    send(8'h5A, 0);
    exp_tx = {8'h3F};
    check_out("rej_unk");

    // Restart while running
    send(8'h52, 0);
    send(8'h01, 0);
    send(8'h23, 0);
    chk("rst_arm", {cpu_reset, mem_own, start_address}, {1'b1, 1'b1, 9'h123});
    step(1);
    chk("rst_go", {cpu_reset, mem_own}, 2'b00);
    exp_tx = {8'h4B};
    check_out("restart");

    // Halt: cpu answers 50 cycles later
    send(8'h48, 0);
    for (int i = 0; i < 50; i++) begin
      chk("halt_hold", {cpu_halt, cpu_reset, mem_own}, 3'b100);
      step(1);
    end
    cpu_halted = 1'b1;
    step(1);
    chk("halt_done", {cpu_halt, cpu_reset, mem_own}, 3'b011);
    cpu_halted = 1'b0;
    exp_tx = {8'h4B};
    check_out("halt");

    do_dump(16'h0002, 64, 0, "regdump");

    // Zero counts and halt while already in reset
    ld_dat.delete();
    do_load(16'h0000, 0, 0, "zero_l");
    do_dump(16'h1234, 0, 0, "zero_d");
    send(8'h48, 0);
    exp_tx = {8'h4B};
    check_out("halt_idle");

    // Randomized command mix
    ready_rand = 1'b1;
    for (int it = 0; it < 16; it++) begin
      a   = $urandom_range(0, 1) ? 16'($urandom) : (16'h01F0 | 16'($urandom_range(0, 15)));
      c   = $urandom_range(0, 20);
      gap = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0: begin
          fill_rand(c);
          do_load(a, c, gap, "rnd_l");
        end
        1: do_dump(a, c, gap, "rnd_d");
        2: begin
          b = 8'($urandom);
          while (b inside {8'h4C, 8'h44, 8'h52, 8'h48}) b = 8'($urandom);
          send(b, gap);
          exp_tx = {8'h3F};
          check_out("rnd_unk");
        end
        default: begin
          send(8'h48, gap);
          exp_tx = {8'h4B};
          check_out("rnd_h");
        end
      endcase
    end
    ready_rand = 1'b0;
    step(2);

    // Reset drops a pending reply
    ready_fix = 1'b0;
    send(8'h5A, 0);
    step(1);
    chk("pend_vld", {tx_valid, tx_data}, {1'b1, 8'h3F});
    reset = 1'b1;
    step(1);
    chk("pend_drop", tx_valid, 0);
    reset = 1'b0;
    ready_fix = 1'b1;
    step(3);
    chk("pend_none", tx_q.size(), 0);

    // Reset after two of three load data bytes
    fill_rand(2);
    send(8'h4C, 0);
    send16(16'h0030, 0);
    send16(16'h0003, 0);
    send(ld_dat[0], 0);
    send(ld_dat[1], 0);
    ref_mem[9'h030] = ld_dat[0];
    ref_mem[9'h031] = ld_dat[1];
    exp_wr.push_back({9'h030, ld_dat[0]});
    exp_wr.push_back({9'h031, ld_dat[1]});
    reset = 1'b1;
    step(1);
    chk_rst("midrst");
    reset = 1'b0;
    step(1);
    send(8'hD3, 0);  // would have been the third data byte; now a bad command
    exp_tx = {8'h3F};
    check_out("abort");
    send(8'h48, 0);
    exp_tx = {8'h4B};
    check_out("post_h");
    do_dump(16'h0030, 2, 0, "post_d");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
